pll_lock_supervisor: RTL
========================

PLL_LOCK_SUPERVISOR -- requirements
Module: pll_lock_supervisor

Interface
REQ-001 SHALL have parameter PLL_RST_CYCLES, default 16: cycles pll_rst_o is held high per reset attempt.
REQ-002 SHALL have parameter LOCK_TIMEOUT_CYCLES, default 4096: maximum cycles spent waiting for lock before a retry.
REQ-003 SHALL have parameter LOCK_STABLE_CYCLES, default 1024: consecutive cycles of lock required before release.
REQ-004 SHALL have parameter MAX_RETRIES, default 3: number of timed-out attempts tolerated before fault.
REQ-005 SHALL have port clk, input, 1: 25 MHz board reference clock, the only clock.
REQ-006 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have port pll_locked_i, input, 1: PLL lock indication, asynchronous to clk.
REQ-008 SHALL have port force_relock_i, input, 1: single-cycle request to restart the PLL.
REQ-009 SHALL have port pll_rst_o, output, 1: active-high reset to the PLL.
REQ-010 SHALL have port sys_rst_o, output, 1: active-high reset for PLL-clocked logic; consumers resynchronise.
REQ-011 SHALL have port lock_ok_o, output, 1: high only in RUN.
REQ-012 SHALL have port fault_o, output, 1: high only in FAULT.
REQ-013 SHALL have port retry_cnt_o, output, 4: timed-out attempts since the last RUN entry.
REQ-014 SHALL have port loss_cnt_o, output, 8: saturating count of lock losses observed in RUN.

Function
REQ-015 SHALL pass pll_locked_i through a 2-flop synchroniser; "locked" below means the synchronised value (2-cycle latency).
REQ-016 SHALL implement the FSM states RESET_PLL, WAIT_LOCK, STABLE, RUN and FAULT.
REQ-017 RESET_PLL SHALL drive pll_rst_o=1 for exactly PLL_RST_CYCLES cycles, then go to WAIT_LOCK with the counter cleared.
REQ-018 WAIT_LOCK: locked=1 SHALL go to STABLE; after LOCK_TIMEOUT_CYCLES without lock it SHALL increment retry_cnt_o and go to RESET_PLL.
REQ-019 A WAIT_LOCK timeout with retry_cnt_o already equal to MAX_RETRIES SHALL go to FAULT instead, leaving retry_cnt_o unchanged.
REQ-020 STABLE SHALL go to RUN after LOCK_STABLE_CYCLES consecutive locked=1 cycles; any locked=0 SHALL return it to WAIT_LOCK with a fresh timeout.
REQ-021 Entry to RUN SHALL clear retry_cnt_o.
REQ-022 sys_rst_o SHALL be 1 in every state except RUN.
REQ-023 RUN: locked=0 SHALL assert sys_rst_o registered on that same edge, increment loss_cnt_o (saturating at 255) and go to RESET_PLL.
REQ-024 FAULT SHALL hold pll_rst_o=1 and sys_rst_o=1 and SHALL be left only via reset_n or force_relock_i.
REQ-025 force_relock_i=1 in any state SHALL go to RESET_PLL with the counter restarted; retry_cnt_o is cleared only when leaving FAULT.
REQ-026 force_relock_i SHALL take priority over every simultaneous transition, including timeout and lock loss.
REQ-027 A single shared cycle counter SHALL be used, sized to hold the largest of the three cycle parameters, and cleared on every state change.
REQ-028 All outputs SHALL be registered.

Reset
REQ-029 On reset_n=0 the block SHALL immediately enter RESET_PLL with the counter at 0.
REQ-030 Reset SHALL force pll_rst_o=1, sys_rst_o=1, lock_ok_o=0, fault_o=0, retry_cnt_o=0, loss_cnt_o=0 and both synchroniser flops to 0.
REQ-031 Assertion of reset_n mid-operation (any state) SHALL abort to the reset values above with no partial count retained.

Structure
REQ-032 The FSM state encoding localparams SHALL live in the shared package pll_sup_pkg.
REQ-033 The synchroniser SHALL be the sub-module sync_2ff (parameterless, 1 bit).

Verification
All scenarios use PLL_RST_CYCLES=4, LOCK_TIMEOUT_CYCLES=32, LOCK_STABLE_CYCLES=8, MAX_RETRIES=2.
REQ-034 Clean start: locked rises 10 cycles after reset release -> pll_rst_o high 4 cycles; lock_ok_o=1 and sys_rst_o=0 exactly 2+8 cycles after the rise.
REQ-035 Glitch: locked high 5 cycles, low 1 cycle, then high -> no RUN until 8 consecutive high cycles; retry_cnt_o stays 0.
REQ-036 Never locks -> three 4-cycle pll_rst_o pulses; retry_cnt_o steps 1 then 2; third timeout gives fault_o=1, pll_rst_o=1 steady.
REQ-037 Loss in RUN: locked drops -> sys_rst_o=1 two cycles later, loss_cnt_o+1, pll_rst_o pulse; 256 losses -> loss_cnt_o=255.
REQ-038 In FAULT: pulse force_relock_i -> retry_cnt_o=0, fault_o=0, new 4-cycle pll_rst_o pulse.
REQ-039 force_relock_i on the same cycle as a timeout -> RESET_PLL, retry_cnt_o unchanged.
REQ-040 reset_n asserted mid-STABLE -> all outputs take reset values asynchronously.

Source files
------------

// File: rtl/pll_sup_pkg.sv
// ---------------------------------------------------------------------------
// pll_sup_pkg
// Shared definitions for the PLL lock supervisor: FSM state encodings and a
// small helper used to size the shared cycle counter.
// ---------------------------------------------------------------------------
package pll_sup_pkg;

  localparam logic [2:0] ST_RESET_PLL_ENC = 3'd0;
  localparam logic [2:0] ST_WAIT_LOCK_ENC = 3'd1;
  localparam logic [2:0] ST_STABLE_ENC    = 3'd2;
  localparam logic [2:0] ST_RUN_ENC       = 3'd3;
  localparam logic [2:0] ST_FAULT_ENC     = 3'd4;

  typedef enum logic [2:0] {
    ST_RESET_PLL = ST_RESET_PLL_ENC,
    ST_WAIT_LOCK = ST_WAIT_LOCK_ENC,
    ST_STABLE    = ST_STABLE_ENC,
    ST_RUN       = ST_RUN_ENC,
    ST_FAULT     = ST_FAULT_ENC
  } state_e;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// ---------------------------------------------------------------------------
// sync_2ff
// Two-flop synchroniser for a single asynchronous level.
// Ports:
//   clk     - destination clock
//   reset_n - asynchronous active-low reset, clears both flops
//   d_i     - asynchronous input
//   q_o     - synchronised output (2-cycle latency)
// ---------------------------------------------------------------------------
module sync_2ff (
  input  logic clk,
  input  logic reset_n,
  input  logic d_i,
  output logic q_o
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= d_i;
      r_sync <= r_meta;
    end
  end

  assign q_o = r_sync;

endmodule

// File: rtl/pll_lock_supervisor.sv
// ---------------------------------------------------------------------------
// pll_lock_supervisor
// Sequences PLL reset, waits for lock, qualifies lock stability, releases the
// PLL-domain reset and recovers from lock loss, with bounded retries ending
// in a sticky FAULT that only reset_n or force_relock_i can clear.
// Ports:
//   clk            - reference clock (only clock)
//   reset_n        - asynchronous active-low reset
//   pll_locked_i   - PLL lock, asynchronous to clk
//   force_relock_i - single-cycle restart request, highest priority
//   pll_rst_o      - reset to the PLL (RESET_PLL and FAULT)
//   sys_rst_o      - reset for PLL-clocked logic (all states but RUN)
//   lock_ok_o      - high in RUN
//   fault_o        - high in FAULT
//   retry_cnt_o    - timed-out attempts since the last RUN entry
//   loss_cnt_o     - saturating count of lock losses seen in RUN
// ---------------------------------------------------------------------------
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int PLL_RST_CYCLES      = 16,
  parameter int LOCK_TIMEOUT_CYCLES = 4096,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int MAX_RETRIES         = 3
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       pll_locked_i,
  input  logic       force_relock_i,
  output logic       pll_rst_o,
  output logic       sys_rst_o,
  output logic       lock_ok_o,
  output logic       fault_o,
  output logic [3:0] retry_cnt_o,
  output logic [7:0] loss_cnt_o
);

  localparam int CNT_MAX = max3(PLL_RST_CYCLES, LOCK_TIMEOUT_CYCLES, LOCK_STABLE_CYCLES);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  // Terminal counts: the counter starts at 0 on state entry, so a state that
  // must last N cycles leaves on the edge where the counter reads N-1.
  localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);

  logic             w_locked;
  state_e           r_state,  w_state_next;
  logic [CNT_W-1:0] r_cnt,    w_cnt_next;
  logic [3:0]       r_retry,  w_retry_next;
  logic [7:0]       r_loss,   w_loss_next;
  logic             r_pll_rst, r_sys_rst, r_lock_ok, r_fault;

  sync_2ff u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d_i     (pll_locked_i),
    .q_o     (w_locked)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_RESET_PLL;
      r_cnt     <= '0;
      r_retry   <= '0;
      r_loss    <= '0;
      r_pll_rst <= 1'b1;
      r_sys_rst <= 1'b1;
      r_lock_ok <= 1'b0;
      r_fault   <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_next;
      r_retry   <= w_retry_next;
      r_loss    <= w_loss_next;
      // Outputs are decoded from the next state so they change on the same
      // edge as the state itself (e.g. sys_rst rises on the lock-loss edge).
      r_pll_rst <= (w_state_next == ST_RESET_PLL) || (w_state_next == ST_FAULT);
      r_sys_rst <= (w_state_next != ST_RUN);
      r_lock_ok <= (w_state_next == ST_RUN);
      r_fault   <= (w_state_next == ST_FAULT);
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_retry_next = r_retry;
    w_loss_next  = r_loss;

    if (force_relock_i) begin
      w_state_next = ST_RESET_PLL;
      if (r_state == ST_FAULT) begin
        w_retry_next = '0;
      end
    end else begin
      case (r_state)
        ST_RESET_PLL: begin
          w_cnt_next = r_cnt + 1'b1;
          if (r_cnt == RST_LAST) begin
            w_state_next = ST_WAIT_LOCK;
          end
        end
        ST_WAIT_LOCK: begin
          w_cnt_next = r_cnt + 1'b1;
          if (w_locked) begin
            w_state_next = ST_STABLE;
          end else if (r_cnt == TIMEOUT_LAST) begin
            if (r_retry == 4'(MAX_RETRIES)) begin
              w_state_next = ST_FAULT;
            end else begin
              w_retry_next = r_retry + 4'd1;
              w_state_next = ST_RESET_PLL;
            end
          end
        end
        ST_STABLE: begin
          w_cnt_next = r_cnt + 1'b1;
          if (!w_locked) begin
            w_state_next = ST_WAIT_LOCK;
          end else if (r_cnt == STABLE_LAST) begin
            w_state_next = ST_RUN;
            w_retry_next = '0;
          end
        end
        ST_RUN: begin
          if (!w_locked) begin
            w_state_next = ST_RESET_PLL;
            if (r_loss != 8'hFF) begin
              w_loss_next = r_loss + 8'd1;
            end
          end
        end
        ST_FAULT: begin
          w_state_next = ST_FAULT;
        end
        default: begin
          w_state_next = ST_RESET_PLL;
        end
      endcase
    end

    // A forced relock into RESET_PLL is not a state change when already there,
    // but the attempt must still restart from zero.
    if ((w_state_next != r_state) || force_relock_i) begin
      w_cnt_next = '0;
    end
  end

  assign pll_rst_o   = r_pll_rst;
  assign sys_rst_o   = r_sys_rst;
  assign lock_ok_o   = r_lock_ok;
  assign fault_o     = r_fault;
  assign retry_cnt_o = r_retry;
  assign loss_cnt_o  = r_loss;

endmodule
